// File: rtl/fp_align_stage.sv
// fp_align_stage: two-stage FP32 operand alignment (select big operand, shift small mantissa, G/R/S).
// Optional feature macro: FP_ALIGN_STICKY_EN (sticky OR-reduce; undefined => sticky tied 0, truncate).
`default_nettype none

module clamp8 (
  input  logic [7:0] diff_i,
  output logic [4:0] shamt_o,
  output logic       ge24_o
);
  assign ge24_o  = (diff_i >= 8'd24);
  assign shamt_o = ge24_o ? 5'd24 : diff_i[4:0];
endmodule

module fp_align_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic [23:0] man_a,
  input  logic [23:0] man_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_big,
  output logic [23:0] man_big,
  output logic [23:0] man_small_al,
  output logic        guard,
  output logic        round,
  output logic        sticky,
  output logic        swapped,
  output logic        shift_ge24
);

  logic        s1_valid_q;
  logic        s2_valid_q;
  logic        s2_load;
  logic        s1_load;

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;

  // ---------------- Stage 1: operand select and shift-amount decode
  logic        a_big;
  logic [7:0]  big_exp_d;
  logic [7:0]  small_exp_d;
  logic [23:0] big_man_d;
  logic [23:0] small_man_d;
  logic [7:0]  diff_d;
  logic [7:0]  diff_m24_d;
  logic [4:0]  shamt_d;
  logic        ge24_d;
  logic [1:0]  excess_d;

  assign a_big       = (exp_a >= exp_b);
  assign big_exp_d   = a_big ? exp_a : exp_b;
  assign small_exp_d = a_big ? exp_b : exp_a;
  assign big_man_d   = a_big ? man_a : man_b;
  assign small_man_d = a_big ? man_b : man_a;
  assign diff_d      = big_exp_d - small_exp_d;

  clamp8 u_clamp8 (
    .diff_i  (diff_d),
    .shamt_o (shamt_d),
    .ge24_o  (ge24_d)
  );

  // Extra shift beyond 24 so G/R/S still see bits for diff 25..27+.
  assign diff_m24_d = diff_d - 8'd24;
  assign excess_d   = !ge24_d             ? 2'd0 :
                      (diff_m24_d > 8'd3) ? 2'd3 : diff_m24_d[1:0];

  logic [7:0]  s1_exp_q;
  logic [23:0] s1_man_big_q;
  logic [23:0] s1_man_small_q;
  logic [4:0]  s1_shamt_q;
  logic [1:0]  s1_excess_q;
  logic        s1_swapped_q;
  logic        s1_ge24_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (s2_load)  s2_valid_q <= s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_exp_q       <= 8'd0;
      s1_man_big_q   <= 24'd0;
      s1_man_small_q <= 24'd0;
      s1_shamt_q     <= 5'd0;
      s1_excess_q    <= 2'd0;
      s1_swapped_q   <= 1'b0;
      s1_ge24_q      <= 1'b0;
    end else if (s1_load) begin
      s1_exp_q       <= big_exp_d;
      s1_man_big_q   <= big_man_d;
      s1_man_small_q <= small_man_d;
      s1_shamt_q     <= shamt_d;
      s1_excess_q    <= excess_d;
      s1_swapped_q   <= !a_big;
      s1_ge24_q      <= ge24_d;
    end
  end

  // ---------------- Stage 2: alignment shift (effective shift = min(diff, 27))
  logic [4:0]  eff_sh;
  logic [23:0] al_d;
  logic        g_d;
  logic        r_d;
  logic        s2_capture;

  assign eff_sh     = s1_shamt_q + {3'b000, s1_excess_q};
  assign s2_capture = s2_load && s1_valid_q;

`ifdef FP_ALIGN_STICKY_EN
  logic [26:0] vec27;
  logic [26:0] shifted27;
  logic [26:0] lost_mask;
  logic        s_d;
  logic        s2_sticky_q;

  assign vec27     = {s1_man_small_q, 3'b000};
  assign shifted27 = vec27 >> eff_sh;
  assign lost_mask = ~({27{1'b1}} << eff_sh);
  assign al_d      = shifted27[26:3];
  assign g_d       = shifted27[2];
  assign r_d       = shifted27[1];
  assign s_d       = shifted27[0] | (|(vec27 & lost_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          s2_sticky_q <= 1'b0;
    else if (s2_capture) s2_sticky_q <= s_d;
  end

  assign sticky = s2_sticky_q;
`else
  // Bit 0 of the 27-bit result only feeds sticky, so a 26-bit shift suffices.
  logic [25:0] vec26;
  logic [25:0] shifted26;

  assign vec26     = {s1_man_small_q, 2'b00};
  assign shifted26 = vec26 >> eff_sh;
  assign al_d      = shifted26[25:2];
  assign g_d       = shifted26[1];
  assign r_d       = shifted26[0];
  assign sticky    = 1'b0;
`endif

  logic [7:0]  s2_exp_q;
  logic [23:0] s2_man_big_q;
  logic [23:0] s2_al_q;
  logic        s2_g_q;
  logic        s2_r_q;
  logic        s2_swapped_q;
  logic        s2_ge24_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_exp_q     <= 8'd0;
      s2_man_big_q <= 24'd0;
      s2_al_q      <= 24'd0;
      s2_g_q       <= 1'b0;
      s2_r_q       <= 1'b0;
      s2_swapped_q <= 1'b0;
      s2_ge24_q    <= 1'b0;
    end else if (s2_capture) begin
      s2_exp_q     <= s1_exp_q;
      s2_man_big_q <= s1_man_big_q;
      s2_al_q      <= al_d;
      s2_g_q       <= g_d;
      s2_r_q       <= r_d;
      s2_swapped_q <= s1_swapped_q;
      s2_ge24_q    <= s1_ge24_q;
    end
  end

  assign out_valid    = s2_valid_q;
  assign exp_big      = s2_exp_q;
  assign man_big      = s2_man_big_q;
  assign man_small_al = s2_al_q;
  assign guard        = s2_g_q;
  assign round        = s2_r_q;
  assign swapped      = s2_swapped_q;
  assign shift_ge24   = s2_ge24_q;

endmodule

`default_nettype wire

// File: doc/fp_align_stage.md
# fp_align_stage

Floating-point operand alignment stage for the FP32 add path of the TPU accumulator. It takes two unpacked operands, each an 8-bit biased exponent and a 24-bit mantissa with the hidden bit included. It selects the larger-exponent operand and right-shifts the smaller mantissa by the exponent difference, producing guard, round and sticky bits. The shift amount comes from the existing `clamp8` 8-bit clamp-to-24 block, instantiated in stage 1. Results feed the mantissa adder downstream. The block is a 2-stage valid/ready pipeline.

## Interface
- No parameters; widths fixed (exp 8, mantissa 24).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input operand pair valid.
- `in_ready` out 1: stage can accept the input pair this cycle.
- `exp_a`, `exp_b` in 8: biased exponents.
- `man_a`, `man_b` in 24: mantissas, bit 23 = hidden bit.
- `out_valid` out 1: output valid.
- `out_ready` in 1: downstream accepts output.
- `exp_big` out 8: exponent of the selected larger operand.
- `man_big` out 24: mantissa of the larger operand, unshifted.
- `man_small_al` out 24: aligned smaller mantissa.
- `guard`, `round`, `sticky` out 1 each: bits shifted out below `man_small_al`.
- `swapped` out 1: 1 when operand b was selected as big.
- `shift_ge24` out 1: exponent difference ≥ 24, taken from `clamp8`.

## Operation
- **Stage 1 (S1) register captures:**
  - Operand select: big = a if `exp_a >= exp_b`, else b. On a tie, a is selected and `swapped`=0.
  - diff = big exp − small exp, 8-bit unsigned, range 0..255.
  - `clamp8` converts diff into shamt (0..24) and `shift_ge24`.
  - excess = min(diff−24, 3) when `shift_ge24`, else 0. 2 bits.
  - Registered: big exp/mantissa, small mantissa, shamt, excess, `swapped`, `shift_ge24`.
- **Stage 2 (S2) register captures:**
  - Form the 27-bit vector {man_small, 3'b000} and shift it right by shamt + excess. Effective shift = min(diff, 27).
  - `man_small_al` = result[26:3], `guard` = result[2], `round` = result[1].
  - `sticky` = result[0] OR'd with every bit shifted out below bit 0.
- **Exact required results:**
  - diff ≤ 23: normal shift.
  - diff = 24: al=0, G=m[23], R=m[22], S=|m[21:0].
  - diff = 25: al=0, G=0, R=m[23], S=|m[22:0].
  - diff ≥ 26: al=0, G=R=0, S=|m.
- **Handshake:**
  - Each stage holds a valid bit.
  - S2 loads when `!s2_valid || out_ready`.
  - S1 advances into S2 under that condition.
  - `in_ready = !s1_valid || !s2_valid || out_ready`. This path is combinational from `out_ready`.
  - A transfer occurs on `in_valid && in_ready` at the input and on `out_valid && out_ready` at the output.
  - Data in a stage is held stable while it is not consumed.
  - Order is preserved; no drop, no duplication.
- **Simultaneous events:** S2 consume, S1→S2 move and a new S1 capture may all occur in the same cycle, sustaining one result per cycle.

## Timing
- Latency: 2 cycles from input accept to `out_valid`, when unstalled.
- Throughput: 1 pair per cycle with `out_ready` held high.
- **Reset values:** all outputs are 0 during and after reset, including `out_valid`=0. `in_ready` is 1 one cycle after reset deasserts, and combinationally 1 while both valid bits are 0.
- **Reset mid-operation:** asserting `rst_n` low clears both valid bits immediately. In-flight pairs are discarded. No output is produced for them after release.
- **Capacity:** up to 2 pairs held while `out_ready`=0. `in_ready`=0 when both stages are full and `out_ready`=0.
- `out_*` data changes only on an S2 load.

## Configuration
- Macro: `FP_ALIGN_STICKY_EN`.
- **Defined:** sticky is computed as specified.
- **Undefined:** `sticky` is tied 0, shifted-out bits below `round` are discarded (truncate), and the OR-reduce logic is absent. All other outputs are identical in both builds.

## Test plan
- Diff 2: exp_a=130, man_a=0x800000, exp_b=128, man_b=0xC00001 → exp_big=130, man_big=0x800000, man_small_al=0x300000, G=0, R=1, S=0, swapped=0, shift_ge24=0, two cycles after accept.
- Swap, far: exp_a=100, man_a=0x800001, exp_b=127, man_b=0x800000 → swapped=1, exp_big=127, shift_ge24=1, man_small_al=0, G=R=0, S=1 (S=0 when the macro is undefined).
- Boundary diff 24: exp_a=150, man_a=0x800000, exp_b=126, man_b=0xC00000 → man_small_al=0, G=1, R=1, S=0, shift_ge24=1. Diff 25 with man_b=0xC00000 → G=0, R=1, S=1.
- Tie: exp_a=exp_b=127, man_a=0x900000, man_b=0xA00000 → swapped=0, man_big=0x900000, man_small_al=0xA00000, G=R=S=0.
- Backpressure: `out_ready`=0 for 5 cycles while 4 back-to-back pairs are offered → exactly 2 accepted, then `in_ready`=0 and outputs held stable. When `out_ready`=1, all 4 results emerge in order, one per cycle, none lost.
- Reset mid-flight: two pairs in the pipe, `rst_n` pulsed low for 1 cycle → `out_valid` falls immediately, no stale result emerges after release, and `in_ready`=1.
